// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D conversion scheduler: channel index, A2D addresses, FSM states, cmd format.
package a2d_pkg;

  typedef logic [1:0] chan_idx_t;

  localparam logic [2:0] ADDR_LFT   = 3'd0;
  localparam logic [2:0] ADDR_RGHT  = 3'd4;
  localparam logic [2:0] ADDR_STEER = 3'd5;
  localparam logic [2:0] ADDR_BATT  = 3'd6;

  // cmd layout is {2'b00, addr[2:0], 11'h000}
  localparam logic [15:0] CMD_TMPL     = 16'h0000;
  localparam int          CMD_ADDR_LSB = 11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WAIT1,
    S_GAP,
    S_READ,
    S_WAIT2,
    S_STORE
  } state_t;

  function automatic logic [2:0] chan_addr(input chan_idx_t idx);
    case (idx)
      2'd0:    return ADDR_LFT;
      2'd1:    return ADDR_RGHT;
      2'd2:    return ADDR_STEER;
      default: return ADDR_BATT;
    endcase
  endfunction

  function automatic logic [15:0] mk_cmd(input chan_idx_t idx);
    return CMD_TMPL | (16'(chan_addr(idx)) << CMD_ADDR_LSB);
  endfunction

endpackage

// File: rtl/a2d_sched_if.sv
// SPI master handshake seen by the scheduler: wrt/cmd out, done/rd_data back.
interface a2d_sched_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;

  modport master (output wrt, output cmd, input done, input rd_data);
  modport slave  (input wrt, input cmd, output done, output rd_data);
endinterface

// File: rtl/a2d_sched.sv
// Round-robin A2D scheduler: two SPI transactions per channel, keeps latest results; A2D_AVG_EN enables averaging.
// nxt->vld spans 2*T_spi+GAP_CYC+4 clocks counting both ends; no backpressure, nxt outside IDLE is dropped.
module a2d_sched
  import a2d_pkg::*;
#(
  parameter int WDOG_CYC = 1024,
  parameter int GAP_CYC  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  a2d_sched_if.master spi,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        vld,
  output chan_idx_t   chan,
  output logic        wdog_err,
  input  logic        err_clr
);

  localparam int CNT_MAX = (WDOG_CYC > GAP_CYC) ? WDOG_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  chan_idx_t        ptr_q, ptr_d;
  logic [15:0]      cmd_q, cmd_d;
  logic             wdog_q;
  logic [11:0]      res_q [4];
  logic [11:0]      store_val;
  logic             store;
  logic             wdog_set;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    cmd_d    = cmd_q;
    store    = 1'b0;
    wdog_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (nxt) begin
          state_d = S_CMD;
          cmd_d   = mk_cmd(ptr_q);
        end
      end
      S_CMD: begin
        state_d = S_WAIT1;
        cnt_d   = '0;
      end
      S_WAIT1, S_WAIT2: begin
        if (spi.done) begin
          state_d = (state_q == S_WAIT1) ? S_GAP : S_STORE;
          store   = (state_q == S_WAIT2);
          cnt_d   = '0;
        end else if (cnt_q == WDOG_LAST) begin
          state_d  = S_IDLE;
          ptr_d    = ptr_q + 2'd1;
          wdog_set = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) state_d = S_READ;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      S_READ: begin
        state_d = S_WAIT2;
        cnt_d   = '0;
      end
      S_STORE: begin
        state_d = S_IDLE;
        ptr_d   = ptr_q + 2'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef A2D_AVG_EN
  logic [3:0]  seen_q;
  logic [12:0] avg_sum;

  always_comb begin
    avg_sum   = {1'b0, res_q[ptr_q]} + {1'b0, spi.rd_data[11:0]} + 13'd1;
    store_val = seen_q[ptr_q] ? 12'(avg_sum >> 1) : spi.rd_data[11:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     seen_q        <= '0;
    else if (store) seen_q[ptr_q] <= 1'b1;
  end
`else
  always_comb store_val = spi.rd_data[11:0];
`endif

  // Result is captured as the second done arrives so it is already visible while vld is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      cmd_q   <= '0;
      wdog_q  <= 1'b0;
      for (int i = 0; i < 4; i++) res_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      cmd_q   <= cmd_d;
      if (wdog_set)     wdog_q <= 1'b1;
      else if (err_clr) wdog_q <= 1'b0;
      if (store) res_q[ptr_q] <= store_val;
    end
  end

  assign spi.wrt   = (state_q == S_CMD) || (state_q == S_READ);
  assign spi.cmd   = cmd_q;
  assign vld       = (state_q == S_STORE);
  assign chan      = ptr_q;
  assign wdog_err  = wdog_q;
  assign lft_ld    = res_q[0];
  assign rght_ld   = res_q[1];
  assign steer_pot = res_q[2];
  assign batt      = res_q[3];

endmodule

// File: tb/tb_a2d_sched.sv
// Bench for a2d_sched: randomized SPI latencies/data against a channel-level reference model.
module tb_a2d_sched;

  localparam int WDOG = 1024;
  localparam int GAP  = 2;

  logic        clk = 1'b0;
  logic        rst_n, nxt, err_clr;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic        vld, wdog_err;
  logic [1:0]  chan;

  a2d_sched_if spi_bus ();

  a2d_sched #(.WDOG_CYC(WDOG), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .nxt(nxt), .spi(spi_bus),
    .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt),
    .vld(vld), .chan(chan), .wdog_err(wdog_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  // SPI slave model: done T clocks after wrt; first response of each pair is junk.
  logic [11:0] spi_val = '0;
  int          spi_lat = 2;
  bit          spi_hang = 1'b0;
  int          cnt_down = 0;
  bit          second = 1'b0;
  int          wrt_cnt = 0;
  int          vld_cnt = 0;
  logic [15:0] wrt_cmds[$];
  logic [15:0] done_cmds[$];

  always @(negedge clk) begin
    spi_bus.done = 1'b0;
    if (!rst_n) begin
      cnt_down = 0;
      second   = 1'b0;
    end else begin
      if (cnt_down > 0) begin
        cnt_down--;
        if (cnt_down == 0 && !spi_hang) begin
          spi_bus.done    = 1'b1;
          spi_bus.rd_data = {4'($urandom), second ? spi_val : 12'($urandom)};
          done_cmds.push_back(spi_bus.cmd);
          second = !second;
        end
      end
      if (spi_bus.wrt) begin
        wrt_cnt++;
        wrt_cmds.push_back(spi_bus.cmd);
        cnt_down = spi_lat;
      end
      if (vld) vld_cnt++;
    end
  end

  // Reference state at the level of channels and result values.
  logic [11:0] exp_res [4];
  int          exp_ptr;
`ifdef A2D_AVG_EN
  bit          exp_seen [4];
`endif

  function automatic int addr_of(input int i);
    return (i == 0) ? 0 : i + 3;
  endfunction

  function automatic logic [11:0] get_reg(input int i);
    case (i)
      0:       return lft_ld;
      1:       return rght_ld;
      2:       return steer_pot;
      default: return batt;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      exp_res[i] = '0;
`ifdef A2D_AVG_EN
      exp_seen[i] = 1'b0;
`endif
    end
    exp_ptr = 0;
  endtask

  task automatic model_store(input logic [11:0] val);
`ifdef A2D_AVG_EN
    if (exp_seen[exp_ptr]) exp_res[exp_ptr] = 12'((int'(exp_res[exp_ptr]) + int'(val) + 1) / 2);
    else                   exp_res[exp_ptr] = val;
    exp_seen[exp_ptr] = 1'b1;
`else
    exp_res[exp_ptr] = val;
`endif
    exp_ptr = (exp_ptr + 1) % 4;
  endtask

  task automatic do_conv(input logic [11:0] val, input int lat, input bit spam);
    int n, v, wc0, vc0, q0, d0;
    bit got;
    logic [15:0] exp_cmd;
    spi_val = val;
    spi_lat = lat;
    wc0 = wrt_cnt; vc0 = vld_cnt; q0 = wrt_cmds.size(); d0 = done_cmds.size();
    exp_cmd = 16'(addr_of(exp_ptr) * 2048);
    n = cyc;
    nxt = 1'b1;
    @(posedge clk); #2;
    nxt = 1'b0;
    got = 1'b0; v = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (vld) begin
        got = 1'b1; v = cyc;
      end else begin
        nxt = spam ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #2;
      end
    end
    nxt = 1'b0;
    checks++;
    if (!got) begin
      errors++; $display("FAIL conv_timeout ch=%0d: no vld within 300 clocks", exp_ptr);
    end else begin
      checks++;
      if (chan !== 2'(exp_ptr)) begin
        errors++; $display("FAIL chan got=%0d exp=%0d", chan, exp_ptr);
      end
      checks++;
      if ((v - n + 1) != 2 * lat + GAP + 4) begin
        errors++; $display("FAIL latency ch=%0d got=%0d exp=%0d clocks", exp_ptr, v - n + 1, 2 * lat + GAP + 4);
      end
    end
    repeat (2) begin @(posedge clk); #2; end
    checks++;
    if (vld_cnt - vc0 != 1) begin
      errors++; $display("FAIL vld_count got=%0d exp=1", vld_cnt - vc0);
    end
    checks++;
    if (wrt_cnt - wc0 != 2) begin
      errors++; $display("FAIL wrt_count got=%0d exp=2", wrt_cnt - wc0);
    end
    checks++;
    if (wrt_cmds.size() < q0 + 2 || wrt_cmds[q0] !== exp_cmd || wrt_cmds[q0 + 1] !== exp_cmd) begin
      errors++; $display("FAIL cmd_at_wrt got=%h exp=%h", (wrt_cmds.size() > q0) ? wrt_cmds[q0] : 16'hxxxx, exp_cmd);
    end
    checks++;
    if (done_cmds.size() < d0 + 2 || done_cmds[d0] !== exp_cmd || done_cmds[d0 + 1] !== exp_cmd) begin
      errors++; $display("FAIL cmd_at_done got=%h exp=%h", (done_cmds.size() > d0) ? done_cmds[d0] : 16'hxxxx, exp_cmd);
    end
    model_store(val);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (get_reg(i) !== exp_res[i]) begin
        errors++; $display("FAIL result[%0d] got=%h exp=%h", i, get_reg(i), exp_res[i]);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) begin @(posedge clk); #2; end
    checks++; if (spi_bus.wrt !== 1'b0) begin errors++; $display("FAIL rst_wrt got=%b exp=0", spi_bus.wrt); end
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL rst_vld got=%b exp=0", vld); end
    checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL rst_wdog got=%b exp=0", wdog_err); end
    checks++; if (chan !== 2'd0) begin errors++; $display("FAIL rst_chan got=%0d exp=0", chan); end
    checks++; if (spi_bus.cmd !== 16'h0000) begin errors++; $display("FAIL rst_cmd got=%h exp=0000", spi_bus.cmd); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (get_reg(i) !== 12'h000) begin errors++; $display("FAIL rst_result[%0d] got=%h exp=000", i, get_reg(i)); end
    end
    rst_n = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic test_round_robin();
    logic [11:0] vals [4];
    int lats [4];
    vals[0] = 12'h123; vals[1] = 12'h456; vals[2] = 12'h789; vals[3] = 12'hABC;
    lats[0] = 1; lats[1] = 3; lats[2] = 5; lats[3] = 2;
    for (int i = 0; i < 4; i++) do_conv(vals[i], lats[i], 1'b0);
  endtask

  task automatic test_wrap();
    do_conv(12'($urandom), 4, 1'b0);
  endtask

  task automatic test_nxt_ignored();
    do_conv(12'($urandom), 6, 1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++)
      do_conv(12'($urandom), int'($urandom_range(1, 8)), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_watchdog();
    int n, w, vc0;
    bit got;
    spi_hang = 1'b1; spi_lat = 3; vc0 = vld_cnt;
    n = cyc;
    nxt = 1'b1; @(posedge clk); #2; nxt = 1'b0;
    got = 1'b0; w = 0;
    for (int i = 0; i < WDOG + 100 && !got; i++) begin
      if (wdog_err) begin got = 1'b1; w = cyc; end
      else begin @(posedge clk); #2; end
    end
    checks++;
    if (!got || w != n + WDOG + 2) begin
      errors++; $display("FAIL wdog_timing seen=%0d after=%0d exp_after=%0d", got, w - n, WDOG + 2);
    end
    checks++;
    if (vld_cnt != vc0) begin errors++; $display("FAIL wdog_no_vld got=%0d exp=0", vld_cnt - vc0); end
    spi_hang = 1'b0;
    exp_ptr = (exp_ptr + 1) % 4;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (get_reg(i) !== exp_res[i]) begin errors++; $display("FAIL wdog_result[%0d] got=%h exp=%h", i, get_reg(i), exp_res[i]); end
    end
    do_conv(12'($urandom), 2, 1'b0);
    checks++;
    if (wdog_err !== 1'b1) begin errors++; $display("FAIL wdog_sticky got=%b exp=1", wdog_err); end
    err_clr = 1'b1; @(posedge clk); #2; err_clr = 1'b0;
    checks++;
    if (wdog_err !== 1'b0) begin errors++; $display("FAIL wdog_clear got=%b exp=0", wdog_err); end
    // clear and timeout in the same clock
    spi_hang = 1'b1;
    nxt = 1'b1; @(posedge clk); #2; nxt = 1'b0;
    repeat (WDOG) begin @(posedge clk); #2; end
    checks++;
    if (wdog_err !== 1'b0) begin errors++; $display("FAIL wdog_early got=%b exp=0", wdog_err); end
    err_clr = 1'b1; @(posedge clk); #2; err_clr = 1'b0;
    checks++;
    if (wdog_err !== 1'b1) begin errors++; $display("FAIL wdog_set_wins got=%b exp=1", wdog_err); end
    spi_hang = 1'b0;
    exp_ptr = (exp_ptr + 1) % 4;
    err_clr = 1'b1; @(posedge clk); #2; err_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    int wc0, vc0;
    bit got;
    spi_lat = 20; wc0 = wrt_cnt; vc0 = vld_cnt;
    nxt = 1'b1; @(posedge clk); #2; nxt = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (wrt_cnt >= wc0 + 2) got = 1'b1;
      else begin @(posedge clk); #2; end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL mid_second_wrt got=%0d exp=2", wrt_cnt - wc0); end
    repeat (3) begin @(posedge clk); #2; end
    rst_n = 1'b0;
    #1;
    checks++; if (spi_bus.wrt !== 1'b0) begin errors++; $display("FAIL mid_rst_wrt got=%b exp=0", spi_bus.wrt); end
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL mid_rst_vld got=%b exp=0", vld); end
    checks++; if (spi_bus.cmd !== 16'h0000) begin errors++; $display("FAIL mid_rst_cmd got=%h exp=0000", spi_bus.cmd); end
    checks++; if (chan !== 2'd0) begin errors++; $display("FAIL mid_rst_chan got=%0d exp=0", chan); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (get_reg(i) !== 12'h000) begin errors++; $display("FAIL mid_rst_result[%0d] got=%h exp=000", i, get_reg(i)); end
    end
    model_reset();
    repeat (2) begin @(posedge clk); #2; end
    rst_n = 1'b1;
    repeat (30) begin @(posedge clk); #2; end
    checks++;
    if (vld_cnt != vc0) begin errors++; $display("FAIL mid_rst_no_vld got=%0d exp=0", vld_cnt - vc0); end
    do_conv(12'h100, 3, 1'b0);
  endtask

  task automatic test_avg();
    logic [11:0] exp_lft;
    for (int k = 0; k < 3; k++) do_conv(12'($urandom), int'($urandom_range(1, 4)), 1'b0);
    do_conv(12'h201, 2, 1'b0);
`ifdef A2D_AVG_EN
    exp_lft = 12'h181;
`else
    exp_lft = 12'h201;
`endif
    checks++;
    if (lft_ld !== exp_lft) begin errors++; $display("FAIL second_lft got=%h exp=%h", lft_ld, exp_lft); end
  endtask

  initial begin
    rst_n = 1'b0; nxt = 1'b0; err_clr = 1'b0;
    model_reset();
    test_reset();
    test_round_robin();
    test_wrap();
    test_nxt_ignored();
    test_random();
    test_watchdog();
    test_reset_mid();
    test_avg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
